// File: rtl/fetch_controller.sv
// fetch_controller
//   Instruction fetch front end. Issues one 32-bit instruction fetch at a time
//   to instruction memory, buffers up to two returned words with their
//   addresses, and presents them to decode in order. A redirect replaces the
//   fetch PC, flushes the buffer and discards any in-flight response.
//
//   Optional feature: define FETCH_ALIGN_CHECK_EN to flag misaligned redirect
//   targets with a sticky misalign_fault, which blocks fetching until an
//   aligned redirect or reset. Without it, the low two target bits are cleared
//   and misalign_fault is tied low.
//
// Ports
//   clock, reset         single clock, asynchronous active-high reset
//   imem_req_valid/ready fetch request handshake toward instruction memory
//   imem_req_addr        byte address of the requested word
//   imem_resp_valid/data returned instruction word (no back-pressure)
//   redirect_valid/pc    PC change request (branch/jump/trap)
//   inst_valid/ready     handshake toward decode
//   inst_data, inst_pc   instruction word at the buffer head and its address
//   misalign_fault       sticky misaligned-redirect flag
//
// State | meaning
// ------+-------------------------------------------------------------
// REQ   | may issue a request (buffer not full, no fault held)
// WAIT  | one request outstanding, its response will be buffered
// DRAIN | one request outstanding, its response will be discarded
module fetch_controller #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0040_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [63:0] inst_pc,
    output logic        misalign_fault
);

    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] fetch_pc_q;
    logic [63:0] req_pc_q;
    logic [31:0] buf_data_q [2];
    logic [63:0] buf_pc_q   [2];
    logic        head_q;
    logic        tail;
    logic [1:0]  count_q;
    logic        fault_q;
    logic [63:0] redirect_target;
    logic        handshake;
    logic        push;
    logic        pop;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_target = redirect_pc;

    // Sticky until the next redirect, which re-evaluates alignment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            fault_q <= |redirect_pc[1:0];
        end
    end
`else
    logic redirect_low_unused;
    assign redirect_low_unused = ^redirect_pc[1:0];
    assign redirect_target     = {redirect_pc[63:2], 2'b00};
    assign fault_q             = 1'b0;
`endif

    // Reset gates the request combinationally so it drops in the same cycle
    // reset rises, not one edge later.
    assign imem_req_valid = !reset && (state_q == ST_REQ) && (count_q != 2'd2) && !fault_q;
    assign imem_req_addr  = fetch_pc_q;
    assign misalign_fault = fault_q;

    assign handshake = imem_req_valid && imem_req_ready;
    assign push      = (state_q == ST_WAIT) && imem_resp_valid && !redirect_valid;
    assign pop       = inst_valid && inst_ready && !redirect_valid;

    assign inst_valid = (count_q != 2'd0);
    assign inst_data  = buf_data_q[head_q];
    assign inst_pc    = buf_pc_q[head_q];

    // Write slot: the head when empty, the other slot when one entry is held.
    // A push never happens with two entries held, since no request is issued
    // while the buffer is full.
    assign tail = head_q ^ count_q[0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ: begin
                if (handshake) begin
                    state_d = redirect_valid ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = ST_REQ;
                end else if (redirect_valid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A redirect here only moves fetch_pc; the response still
                // has to be swallowed before a new request can go out.
                if (imem_resp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            head_q     <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                req_pc_q <= fetch_pc_q;
            end
            if (redirect_valid) begin
                fetch_pc_q <= redirect_target;
                head_q     <= 1'b0;
                count_q    <= 2'd0;
            end else begin
                if (handshake) begin
                    fetch_pc_q <= fetch_pc_q + 64'd4;
                end
                if (pop) begin
                    head_q <= ~head_q;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 2'd1;
                    2'b01:   count_q <= count_q - 2'd1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_data_q[0] <= 32'd0;
            buf_data_q[1] <= 32'd0;
            buf_pc_q[0]   <= 64'd0;
            buf_pc_q[1]   <= 64'd0;
        end else if (push) begin
            buf_data_q[tail] <= imem_resp_data;
            buf_pc_q[tail]   <= req_pc_q;
        end
    end

endmodule
